vga_plot_scheduler: RTL and testbench

- Owns the single VGA adapter plot bus. Sequences the per-frame draw phases in fixed order: screen clear, tile/map draw, player sprite draw.
- Grants the bus to exactly one requester at a time and muxes that requester's x/y/colour/plot onto registered VGA outputs.
- Replaces the shared tri-state plot bus. Reset by the 60 Hz frame pulse, so every frame restarts the sequence from the clear phase.

---
 rtl/vga_plot_scheduler_if.sv | 32 +++
 rtl/vga_plot_scheduler.sv | 174 +++++++++++++++++
 tb/tb_vga_plot_scheduler.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_plot_scheduler_if.sv
// Plot-bus bundle between the per-frame draw engines and the VGA plot scheduler.
// The master side is the set of draw requesters; the slave side is the scheduler.
interface vga_plot_scheduler_if;
   logic [2:0]  req;
   logic [2:0]  done;
   logic [2:0]  plot_in;
   logic [23:0] x_in;
   logic [20:0] y_in;
   logic [71:0] colour_in;
   logic [2:0]  grant;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [23:0] vga_colour;
   logic        vga_plot;
   logic [1:0]  phase;
   logic        frame_done;
   logic        timeout_flag;
   logic [1:0]  timeout_phase;
   logic [14:0] pixel_count;

   modport master (
      output req, done, plot_in, x_in, y_in, colour_in,
      input  grant, vga_x, vga_y, vga_colour, vga_plot, phase,
             frame_done, timeout_flag, timeout_phase, pixel_count
   );

   modport slave (
      input  req, done, plot_in, x_in, y_in, colour_in,
      output grant, vga_x, vga_y, vga_colour, vga_plot, phase,
             frame_done, timeout_flag, timeout_phase, pixel_count
   );
endinterface

// File: rtl/vga_plot_scheduler.sv
// Per-frame owner of the VGA plot bus: clear -> tiles -> sprite -> done, one
// granted requester at a time, its pixel registered onto the adapter outputs.
module vga_plot_scheduler #(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int TMO_W          = 17
) (
   input  logic                 CLOCK_50,
   input  logic                 frame_reset,
   vga_plot_scheduler_if.slave  bus
);

   typedef enum logic [1:0] {
      S_CLEAR  = 2'd0,
      S_TILES  = 2'd1,
      S_SPRITE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [14:0]      PIX_MAX  = 15'h7FFF;

   function automatic logic [14:0] sat_inc(input logic [14:0] v);
      return (v == PIX_MAX) ? v : v + 15'd1;
   endfunction

   function automatic logic [2:0] onehot_grant(input state_t s);
      logic [2:0] g;
      case (s)
         S_CLEAR:  g = 3'b001;
         S_TILES:  g = 3'b010;
         S_SPRITE: g = 3'b100;
         default:  g = 3'b000;
      endcase
      return g;
   endfunction

   state_t           state, state_next;
   logic [2:0]       grant_q, grant_next;
   logic [TMO_W-1:0] phase_cnt;
   logic             held, cur_req, cur_done, at_limit, advance, timed_out;
   logic             frame_done_q, tmo_flag;
   logic [1:0]       tmo_phase;

   // Datapath stage p0 is the granted-slot mux, p1 the registered adapter outputs.
   logic             vld_p0, vld_p1;
   logic [7:0]       x_p0, x_p1;
   logic [6:0]       y_p0, y_p1;
   logic [23:0]      colour_p0, colour_p1;
   logic [14:0]      pix_cnt;

   always_comb begin
      state_next = state;
      held       = 1'b0;
      cur_req    = 1'b0;
      cur_done   = 1'b0;
      case (state)
         S_CLEAR: begin
            held     = grant_q[0];
            cur_req  = bus.req[0];
            cur_done = bus.done[0];
         end
         S_TILES: begin
            held     = grant_q[1];
            cur_req  = bus.req[1];
            cur_done = bus.done[1];
         end
         S_SPRITE: begin
            held     = grant_q[2];
            cur_req  = bus.req[2];
            cur_done = bus.done[2];
         end
         default: ;
      endcase

      at_limit  = (phase_cnt == TMO_LAST);
      advance   = held & (cur_done | ~cur_req | at_limit);
      timed_out = held & cur_req & ~cur_done & at_limit;

      if (advance) begin
         case (state)
            S_CLEAR:  state_next = S_TILES;
            S_TILES:  state_next = S_SPRITE;
            default:  state_next = S_DONE;
         endcase
      end

      // Grant follows the next state so a phase hand-off leaves no idle cycle.
      grant_next = onehot_grant(state_next);
   end

   always_ff @(posedge CLOCK_50 or posedge frame_reset) begin
      if (frame_reset) begin
         state        <= S_CLEAR;
         grant_q      <= 3'b000;
         phase_cnt    <= '0;
         frame_done_q <= 1'b0;
         tmo_flag     <= 1'b0;
         tmo_phase    <= 2'd0;
      end else begin
         state        <= state_next;
         grant_q      <= grant_next;
         frame_done_q <= (state_next == S_DONE);
         if (advance)
            phase_cnt <= '0;
         else if (held)
            phase_cnt <= phase_cnt + 1'b1;
         if (timed_out) begin
            tmo_flag  <= 1'b1;
            tmo_phase <= state;
         end
      end
   end

   // With no grant the coordinates hold and the plot strobe drops.
   always_comb begin
      vld_p0    = 1'b0;
      x_p0      = x_p1;
      y_p0      = y_p1;
      colour_p0 = colour_p1;
      case (grant_q)
         3'b001: begin
            vld_p0    = bus.plot_in[0];
            x_p0      = bus.x_in[7:0];
            y_p0      = bus.y_in[6:0];
            colour_p0 = bus.colour_in[23:0];
         end
         3'b010: begin
            vld_p0    = bus.plot_in[1];
            x_p0      = bus.x_in[15:8];
            y_p0      = bus.y_in[13:7];
            colour_p0 = bus.colour_in[47:24];
         end
         3'b100: begin
            vld_p0    = bus.plot_in[2];
            x_p0      = bus.x_in[23:16];
            y_p0      = bus.y_in[20:14];
            colour_p0 = bus.colour_in[71:48];
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge frame_reset) begin
      if (frame_reset) begin
         vld_p1    <= 1'b0;
         x_p1      <= 8'd0;
         y_p1      <= 7'd0;
         colour_p1 <= 24'd0;
         pix_cnt   <= 15'd0;
      end else begin
         vld_p1    <= vld_p0;
         x_p1      <= x_p0;
         y_p1      <= y_p0;
         colour_p1 <= colour_p0;
         if (vld_p0)
            pix_cnt <= sat_inc(pix_cnt);
      end
   end

   assign bus.grant         = grant_q;
   assign bus.phase         = state;
   assign bus.frame_done    = frame_done_q;
   assign bus.timeout_flag  = tmo_flag;
   assign bus.timeout_phase = tmo_phase;
   assign bus.vga_plot      = vld_p1;
   assign bus.vga_x         = x_p1;
   assign bus.vga_y         = y_p1;
   assign bus.vga_colour    = colour_p1;
   assign bus.pixel_count   = pix_cnt;

   a_grant_onehot0 : assert property (@(posedge CLOCK_50) disable iff (frame_reset)
      $onehot0(grant_q));

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Scoreboarded bench for vga_plot_scheduler: three frames covering a full clear,
// skipped tiles, plot+done on one edge, phase timeouts and a mid-phase reset.
module tb_vga_plot_scheduler;

   localparam int TMO = 20000;

   typedef struct {
      logic        plot;
      logic [7:0]  x;
      logic [6:0]  y;
      logic [23:0] c;
      logic        cmp_xy;
   } pix_t;

   logic CLOCK_50 = 1'b0;
   logic frame_reset;
   int   n_chk  = 0;
   int   n_fail = 0;
   pix_t sb[$];

   vga_plot_scheduler_if bus();

   vga_plot_scheduler #(.TIMEOUT_CYCLES(TMO), .TMO_W(17)) dut (
      .CLOCK_50    (CLOCK_50),
      .frame_reset (frame_reset),
      .bus         (bus)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic set_slot(input int i, input logic p, input logic [7:0] x,
                           input logic [6:0] y, input logic [23:0] c);
      bus.plot_in[i]         = p;
      bus.x_in[8*i +: 8]     = x;
      bus.y_in[7*i +: 7]     = y;
      bus.colour_in[24*i +: 24] = c;
   endtask

   function automatic logic [23:0] colr(input int p, input int s);
      return 24'(p * 7 + s * 32'h0010_0000 + 32'h0000_00A5);
   endfunction

   // One clock: expectation queued with the stimulus, popped when the output lands.
   task automatic step_dp(input logic ep, input logic [7:0] ex, input logic [6:0] ey,
                          input logic [23:0] ec, input logic cmp_xy);
      pix_t e;
      e.plot = ep; e.x = ex; e.y = ey; e.c = ec; e.cmp_xy = cmp_xy;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      check_val("vga_plot", 32'(bus.vga_plot), 32'(e.plot));
      if (e.cmp_xy) begin
         check_val("vga_x", 32'(bus.vga_x), 32'(e.x));
         check_val("vga_y", 32'(bus.vga_y), 32'(e.y));
         check_val("vga_colour", 32'(bus.vga_colour), 32'(e.c));
      end
   endtask

   task automatic quiet_inputs();
      bus.req       = 3'b111;
      bus.done      = 3'b000;
      bus.plot_in   = 3'b000;
      bus.x_in      = '0;
      bus.y_in      = '0;
      bus.colour_in = '0;
   endtask

   task automatic check_ctrl(input string tag, input logic [2:0] g, input logic [1:0] ph,
                             input logic fd, input logic tf);
      check_val({tag, "_grant"}, 32'(bus.grant), 32'(g));
      check_val({tag, "_phase"}, 32'(bus.phase), 32'(ph));
      check_val({tag, "_frame_done"}, 32'(bus.frame_done), 32'(fd));
      check_val({tag, "_timeout_flag"}, 32'(bus.timeout_flag), 32'(tf));
   endtask

   task automatic restart_frame();
      frame_reset = 1'b1;
      tick();
      frame_reset = 1'b0;
      tick();
      check_val("restart_grant", 32'(bus.grant), 32'(3'b001));
   endtask

   initial begin
      #3_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      frame_reset = 1'b1;
      quiet_inputs();
      tick();
      tick();
      check_ctrl("reset", 3'b000, 2'd0, 1'b0, 1'b0);
      check_val("reset_vga_plot", 32'(bus.vga_plot), 32'd0);
      check_val("reset_vga_x", 32'(bus.vga_x), 32'd0);
      check_val("reset_vga_colour", 32'(bus.vga_colour), 32'd0);
      check_val("reset_pixel_count", 32'(bus.pixel_count), 32'd0);
      check_val("reset_timeout_phase", 32'(bus.timeout_phase), 32'd0);

      // Frame 1: full-screen clear with the other engines plotting alongside.
      frame_reset = 1'b0;
      tick();
      check_ctrl("first_edge", 3'b001, 2'd0, 1'b0, 1'b0);
      set_slot(1, 1'b1, 8'd5, 7'd7, colr(5, 1));
      set_slot(2, 1'b1, 8'd9, 7'd3, colr(9, 2));
      for (int g = 0; g < 8; g++) begin
         set_slot(0, 1'b0, 8'd200, 7'd100, colr(g, 0));
         step_dp(1'b0, 8'd200, 7'd100, colr(g, 0), 1'b1);
         check_val("gap_grant", 32'(bus.grant), 32'(3'b001));
      end
      for (int p = 0; p < 19200; p++) begin
         set_slot(0, 1'b1, 8'(p % 160), 7'(p / 160), colr(p, 0));
         step_dp(1'b1, 8'(p % 160), 7'(p / 160), colr(p, 0), 1'b1);
         check_val("clear_grant", 32'(bus.grant), 32'(3'b001));
      end
      set_slot(0, 1'b0, 8'd159, 7'd119, colr(0, 3));
      bus.done = 3'b001;
      step_dp(1'b0, 8'd159, 7'd119, colr(0, 3), 1'b1);
      check_ctrl("clear_end", 3'b010, 2'd1, 1'b0, 1'b0);
      check_val("clear_pixel_count", 32'(bus.pixel_count), 32'd19200);

      // Tile drawer withdrawn on entry; the clear engine's late plot is dropped.
      bus.done = 3'b000;
      bus.req  = 3'b101;
      set_slot(0, 1'b1, 8'd11, 7'd12, colr(11, 0));
      set_slot(1, 1'b0, 8'd21, 7'd22, colr(21, 1));
      step_dp(1'b0, 8'd21, 7'd22, colr(21, 1), 1'b1);
      check_ctrl("tiles_skip", 3'b100, 2'd2, 1'b0, 1'b0);
      check_val("skip_pixel_count", 32'(bus.pixel_count), 32'd19200);

      // Sprite plots and finishes on the same edge.
      bus.req  = 3'b111;
      bus.done = 3'b100;
      bus.plot_in = 3'b000;
      set_slot(2, 1'b1, 8'd64, 7'd8, colr(64, 2));
      step_dp(1'b1, 8'd64, 7'd8, colr(64, 2), 1'b1);
      check_ctrl("sprite_done", 3'b000, 2'd3, 1'b1, 1'b0);
      check_val("sprite_pixel_count", 32'(bus.pixel_count), 32'd19201);

      bus.done = 3'b111;
      set_slot(0, 1'b1, 8'd1, 7'd1, colr(1, 0));
      set_slot(1, 1'b1, 8'd2, 7'd2, colr(2, 1));
      set_slot(2, 1'b1, 8'd3, 7'd3, colr(3, 2));
      step_dp(1'b0, 8'd64, 7'd8, colr(64, 2), 1'b1);
      check_ctrl("done_hold", 3'b000, 2'd3, 1'b1, 1'b0);
      check_val("done_pixel_count", 32'(bus.pixel_count), 32'd19201);

      // Frame 2: sprite holds the bus until forced out.
      quiet_inputs();
      restart_frame();
      check_ctrl("f2_start", 3'b001, 2'd0, 1'b0, 1'b0);
      check_val("f2_pixel_count", 32'(bus.pixel_count), 32'd0);
      bus.done = 3'b001;
      tick();
      check_val("f2_clear_grant", 32'(bus.grant), 32'(3'b010));
      bus.done = 3'b010;
      tick();
      check_val("f2_tiles_grant", 32'(bus.grant), 32'(3'b100));
      bus.done = 3'b000;
      repeat (TMO - 1) tick();
      check_ctrl("sprite_pre_tmo", 3'b100, 2'd2, 1'b0, 1'b0);
      tick();
      check_ctrl("sprite_tmo", 3'b000, 2'd3, 1'b1, 1'b1);
      check_val("sprite_tmo_phase", 32'(bus.timeout_phase), 32'd2);

      // Frame 3: clear times out, tiles plot 300 pixels, then reset mid-phase.
      restart_frame();
      repeat (TMO - 1) tick();
      check_ctrl("clear_pre_tmo", 3'b001, 2'd0, 1'b0, 1'b0);
      tick();
      check_ctrl("clear_tmo", 3'b010, 2'd1, 1'b0, 1'b1);
      check_val("clear_tmo_phase", 32'(bus.timeout_phase), 32'd0);
      for (int k = 0; k < 300; k++) begin
         set_slot(1, 1'b1, 8'(k), 7'(k % 128), colr(k, 1));
         step_dp(1'b1, 8'(k), 7'(k % 128), colr(k, 1), 1'b1);
      end
      check_val("tiles_pixel_count", 32'(bus.pixel_count), 32'd300);
      check_val("tiles_tmo_flag", 32'(bus.timeout_flag), 32'd1);
      frame_reset = 1'b1;
      #1;
      check_ctrl("mid_reset", 3'b000, 2'd0, 1'b0, 1'b0);
      check_val("mid_reset_vga_plot", 32'(bus.vga_plot), 32'd0);
      check_val("mid_reset_pixel_count", 32'(bus.pixel_count), 32'd0);
      check_val("mid_reset_timeout_phase", 32'(bus.timeout_phase), 32'd0);
      tick();
      frame_reset = 1'b0;
      tick();
      check_ctrl("post_reset", 3'b001, 2'd0, 1'b0, 1'b0);
      check_val("post_reset_vga_plot", 32'(bus.vga_plot), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
